inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 150 +++++++++++++++
 tb/tb_inst_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with a small output FIFO.
// Each accepted request is packed into a 32-bit word according to its format
// and checked for an unrepresentable immediate. The word and its error flag
// are then queued in a DEPTH-entry buffer that has a registered head.
module inst_encoder #(
  parameter int DEPTH = 2            // 2 or 4; the pointers rely on a power of two
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  inst_type,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        imm_err,
  output logic [7:0]  err_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] T_U = 3'd0;
  localparam logic [2:0] T_J = 3'd1;
  localparam logic [2:0] T_I = 3'd2;
  localparam logic [2:0] T_S = 3'd3;
  localparam logic [2:0] T_B = 3'd4;
  localparam logic [2:0] T_R = 3'd5;

  // One buffer entry: the encoded word plus the flag that travels with it.
  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } ent_t;

  ent_t [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rdy_en;   // held low through reset and the first edge after it

  logic [31:0] enc_word;
  logic        enc_err;
  logic        push;
  logic        pop;

  // Sign-extension checks: every bit above the format's top bit must equal it.
  logic i_range_bad;
  logic j_range_bad;
  logic b_range_bad;

  assign i_range_bad = (imm[31:12] != {20{imm[11]}});
  assign j_range_bad = (imm[31:21] != {11{imm[20]}});
  assign b_range_bad = (imm[31:13] != {19{imm[12]}});

  // Format-dependent packing and error detection, purely combinational on the inputs.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (inst_type)
      T_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = (imm[11:0] != 12'd0);
      end
      T_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = imm[0] | j_range_bad;
      end
      T_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = i_range_bad;
      end
      T_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = i_range_bad;
      end
      T_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = imm[0] | b_range_bad;
      end
      T_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      default: begin
        // Unknown formats still produce an I-shaped word so the consumer sees
        // something deterministic, but the entry is always flagged.
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = rdy_en && (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign inst    = mem[rd_ptr].word;
  assign imm_err = mem[rd_ptr].err;

  // Ready enable: comes up on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Buffer storage and write pointer; entries are cleared so inst reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{err: enc_err, word: enc_word};
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every pop; wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + 1'b1;
  end

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted requests that carried an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 err_cnt <= '0;
    else if (push && enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a table of hand-encoded vectors, then
// sequences for error saturation, backpressure, streaming and mid-run reset.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  inst_type;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        imm_err;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  inst_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .imm(imm), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .imm_err(imm_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic [2:0] t, logic [31:0] im, logic [6:0] op,
                              logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                              logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] ex, logic er);
    vec_t v;
    v.t = t; v.imm = im; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = f3; v.f7 = f7; v.exp = ex; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    inst_type = v.t; imm = v.imm; opcode = v.op; rd = v.rd;
    rs1 = v.rs1; rs2 = v.rs2; funct3 = v.f3; funct7 = v.f7;
  endtask

  task automatic set_i(input logic [31:0] im);
    inst_type = 3'd2; imm = im; opcode = 7'h13; rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = 0;
  endtask

  // Single request with out_ready=1: accepted on one edge, checked at the head, popped next edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    set_req(v);
    in_valid = 1'b1;
    chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.err && exp_cnt < 255) exp_cnt++;
    chk($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d inst", idx), inst, v.exp);
    chk($sformatf("v%0d imm_err", idx), {31'd0, imm_err}, {31'd0, v.err});
    chk($sformatf("v%0d err_cnt", idx), {24'd0, err_cnt}, exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(3'd2, 32'hFFFFFFFF, 7'h13, 5'd1,  5'd0,  5'h1F, 3'd0, 7'h7F, 32'hFFF00093, 1'b0);
    tbl[1]  = mk(3'd4, 32'hFFFFFFFC, 7'h63, 5'h1F, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFE000EE3, 1'b0);
    tbl[2]  = mk(3'd0, 32'h12345000, 7'h37, 5'd5,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h123452B7, 1'b0);
    tbl[3]  = mk(3'd5, 32'hDEADBEEF, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h402081B3, 1'b0);
    tbl[4]  = mk(3'd3, 32'hFFFFFFF8, 7'h23, 5'd7,  5'd2,  5'd5,  3'd2, 7'h7F, 32'hFE512C23, 1'b0);
    tbl[5]  = mk(3'd1, 32'h00000800, 7'h6F, 5'd1,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h001000EF, 1'b0);
    tbl[6]  = mk(3'd1, 32'h00000003, 7'h6F, 5'd0,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h0020006F, 1'b1);
    tbl[7]  = mk(3'd2, 32'h00000800, 7'h13, 5'd0,  5'd0,  5'h1F, 3'd0, 7'h7F, 32'h80000013, 1'b1);
    tbl[8]  = mk(3'd0, 32'h12345678, 7'h37, 5'd0,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h12345037, 1'b1);
    tbl[9]  = mk(3'd4, 32'h00000011, 7'h63, 5'h1F, 5'd0,  5'd0,  3'd1, 7'h7F, 32'h00001863, 1'b1);
    tbl[10] = mk(3'd4, 32'h00001000, 7'h63, 5'h1F, 5'd0,  5'd0,  3'd0, 7'h7F, 32'h80000063, 1'b1);
    tbl[11] = mk(3'd6, 32'h00000005, 7'h13, 5'd2,  5'd3,  5'h1F, 3'd1, 7'h7F, 32'h00519113, 1'b1);
    tbl[12] = mk(3'd7, 32'hFFFFF800, 7'h13, 5'd0,  5'd0,  5'h1F, 3'd0, 7'h7F, 32'h80000013, 1'b1);
    tbl[13] = mk(3'd3, 32'h00000800, 7'h23, 5'h1F, 5'd0,  5'd0,  3'd0, 7'h7F, 32'h80000023, 1'b1);
    tbl[14] = mk(3'd2, 32'h000007FF, 7'h13, 5'd0,  5'd0,  5'h1F, 3'd0, 7'h7F, 32'h7FF00013, 1'b0);
    tbl[15] = mk(3'd1, 32'hFFF00000, 7'h6F, 5'd0,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h8000006F, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_i(32'd0);

    // Reset state
    #3;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst inst",      inst,               32'd0);
    chk("rst imm_err",   {31'd0, imm_err},   32'd0);
    chk("rst err_cnt",   {24'd0, err_cnt},   32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("pre-edge in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("post-edge in_ready", {31'd0, in_ready}, 32'd1);

    // Encoding table
    for (int i = 0; i < 16; i++) apply(tbl[i], i);
    @(negedge clk);
    chk("table drained", {31'd0, out_valid}, 32'd0);

    // Error counting and saturation
    do_reset();
    apply(tbl[6], 100);
    apply(tbl[7], 101);
    chk("err_cnt two", {24'd0, err_cnt}, 32'd2);
    @(negedge clk);
    set_req(tbl[6]);
    in_valid = 1'b1;
    repeat (253) @(negedge clk);
    chk("err_cnt 255", {24'd0, err_cnt}, 32'd255);
    repeat (47) @(negedge clk);
    in_valid = 1'b0;
    chk("err_cnt sat", {24'd0, err_cnt}, 32'd255);
    chk("sat head flag", {31'd0, imm_err}, 32'd1);

    // Backpressure at DEPTH=2
    do_reset();
    out_ready = 1'b0;
    set_i(32'd1); in_valid = 1'b1;
    chk("bp A ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    set_i(32'd2);
    chk("bp B ready", {31'd0, in_ready}, 32'd1);
    chk("bp head A", inst, 32'h00100013);
    @(negedge clk);
    set_i(32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp full ready %0d", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp stable %0d", k), inst, 32'h00100013);
      chk($sformatf("bp valid %0d", k), {31'd0, out_valid}, 32'd1);
      if (k < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp ready after pop", {31'd0, in_ready}, 32'd1);
    chk("bp head B", inst, 32'h00200013);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp refilled", {31'd0, in_ready}, 32'd0);
    chk("bp head B hold", inst, 32'h00200013);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp head C", inst, 32'h00300013);
    chk("bp C valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp empty", {31'd0, out_valid}, 32'd0);

    // Streaming: one word per cycle
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        chk($sformatf("st valid %0d", i - 1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("st inst %0d", i - 1), inst, (32'(i - 1) * 32'd3 + 32'd7) << 20 | 32'h13);
      end
      chk($sformatf("st ready %0d", i), {31'd0, in_ready}, 32'd1);
      set_i(32'(i) * 32'd3 + 32'd7);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("st valid 19", {31'd0, out_valid}, 32'd1);
    chk("st inst 19", inst, (32'd64 << 20) | 32'h13);
    @(negedge clk);
    chk("st drained", {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered
    out_ready = 1'b0;
    set_req(tbl[6]); in_valid = 1'b1;
    @(negedge clk);
    set_req(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr full", {31'd0, in_ready}, 32'd0);
    chk("mr err_cnt", {24'd0, err_cnt}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr err_cnt clr", {24'd0, err_cnt}, 32'd0);
    chk("mr inst", inst, 32'd0);
    chk("mr imm_err", {31'd0, imm_err}, 32'd0);
    chk("mr in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mr quiet %0d", k), {31'd0, out_valid}, 32'd0);
    end
    set_i(32'h0000_0123); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr new word", inst, 32'h12300013);
    chk("mr new valid", {31'd0, out_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
